lstm_cell_seq: RTL and testbench
================================

LSTM_CELL_SEQ -- requirements
Module: lstm_cell_seq

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 16, word width, signed two's complement.
- FRACT_WIDTH, 8, fractional bits (Q8.8 at defaults).
- IN_DIM, 2, input vector length; K = IN_DIM+1 terms per gate.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, synchronous, active-high reset.
- in_valid, in, 1, step request.
- in_ready, out, 1, block can accept a step.
- seq_start, in, 1, sampled with accept; treat previous c,h as 0.
- x, in, IN_DIM*DATA_WIDTH, element k at [k*DW +: DW].
- w, in, 4*K*DATA_WIDTH, gate g (0=f,1=i,2=g,3=o), term k (k<IN_DIM: x[k]; k=IN_DIM: h_prev) at [(g*K+k)*DW +: DW].
- b, in, 4*DATA_WIDTH, bias g at [g*DW +: DW].
- out_valid, out, 1, c_out/h_out valid.
- out_ready, in, 1, consumer accepts result.
- c_out, out, DATA_WIDTH, new cell state.
- h_out, out, DATA_WIDTH, new hidden state.

Function
REQ-003 Accept SHALL occur on a cycle with in_valid && in_ready; x and seq_start SHALL be registered at accept; w and b SHALL be held stable by the source until out_valid.
REQ-004 FSM states SHALL be IDLE, MAC, ACT, UPD, OUT; in_ready SHALL equal (state==IDLE).
REQ-005 Transitions SHALL be: IDLE->MAC on accept; MAC runs 4*K cycles (gate f,i,g,o order, one product per cycle on a single multiplier) ->ACT; ACT->UPD after 1 cycle; UPD->OUT after 1 cycle; OUT->IDLE on out_ready.
REQ-006 out_valid SHALL rise exactly 4*K+3 cycles after the accept edge (15 at defaults) and stay high until out_ready.
REQ-007 While OUT && !out_ready, c_out/h_out SHALL hold stable and in_valid SHALL be ignored.
REQ-008 Products SHALL be full 2*DW-bit signed; the accumulator SHALL be wide enough for K products plus the bias shifted left by FRACT_WIDTH without overflow.
REQ-009 Gate pre-activation SHALL be: accumulator arithmetic-shifted right by FRACT_WIDTH (truncation toward -inf), then saturated to [-2^(DW-1), 2^(DW-1)-1].
REQ-010 Activations SHALL be piecewise-linear: sigmoid(x)=clamp(0.5+x/4, 0, 1) for f, i, o; tanh(x)=clamp(x, -1, 1) for g and for the cell output.
REQ-011 The UPD cycle SHALL compute c_new = sat((f*c_prev + i*g) >>> F) and h_new = sat((o*tanh(c_new)) >>> F), both with the same rules as REQ-009.
REQ-012 c_new and h_new SHALL be stored internally as c_prev/h_prev for the next step; when seq_start is registered as 1, c_prev and h_prev SHALL read as 0 for that step.

Reset
REQ-013 rst SHALL force IDLE, c_out=0, h_out=0, out_valid=0, and c_prev=h_prev=0, with in_ready=1 on the cycle after rst deasserts.
REQ-014 rst asserted in any state, including mid-MAC or in OUT, SHALL abort the step and discard the partial result.

Structure
REQ-015 Package lstm_pkg SHALL hold DATA_WIDTH/FRACT_WIDTH defaults, the gate index enum, the FSM state enum, and a saturate function.
REQ-016 Sub-module lstm_act SHALL implement the combinational sigmoid/tanh PWL, selected by a mode input, and SHALL be instantiated once and time-shared.

Verification (defaults, Q8.8)
REQ-017 All w=0, b=0, seq_start=1 -> out_valid exactly 15 cycles after accept, c_out=0x0000, h_out=0x0000.
REQ-018 w=0, b={f:0, i:0x0400, g:0x0080, o:0x0400}:
- step 1 with seq_start -> c_out=0x0080, h_out=0x0080.
- step 2 without seq_start -> c_out=0x00C0, h_out=0x00C0.
REQ-019 x=0x7FFF both, Wg all 0x7FFF, bg=0x7FFF, i and o biases 0x0400 -> g saturates, c_out=0x0100, h_out=0x0100.
REQ-020 out_ready held low 10 cycles in OUT -> outputs stable, in_ready=0, pulsed in_valid not accepted; IDLE one cycle after out_ready.
REQ-021 rst pulsed mid-MAC -> out_valid=0 and in_ready=1 after reset; next step without seq_start matches REQ-017 results.

Source files
------------

// File: rtl/lstm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lstm_pkg
//  Description : Shared types and helpers for the sequential LSTM cell:
//                default fixed-point format, gate index and FSM state
//                enumerations, activation mode, and a signed saturator.
//  Revision    : 1.0  initial release
// ============================================================================
package lstm_pkg;

    // Default fixed-point format: Q8.8 in a 16-bit signed word
    localparam int DATA_WIDTH_DFLT  = 16;
    localparam int FRACT_WIDTH_DFLT = 8;
    localparam int IN_DIM_DFLT      = 2;

    // Width of the saturator datapath; wide enough for any accumulator here
    localparam int SAT_W = 64;

    // Gate order is also the order in which the MAC walks the weight bus
    typedef enum logic [1:0] {
        GATE_F = 2'd0,
        GATE_I = 2'd1,
        GATE_G = 2'd2,
        GATE_O = 2'd3
    } gate_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAC  = 3'd1,
        ST_ACT  = 3'd2,
        ST_UPD  = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    typedef enum logic {
        ACT_SIGMOID = 1'b0,
        ACT_TANH    = 1'b1
    } act_mode_t;

    // Clamp a wide signed value into the range of a dw-bit signed word.
    // The result stays SAT_W wide; callers truncate to their word width.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             dw
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lstm_act.sv
`default_nettype none
// ============================================================================
//  Module      : lstm_act
//  Description : Combinational piecewise-linear activation.
//                sigmoid(x) = clamp(0.5 + x/4, 0, 1)
//                tanh(x)    = clamp(x, -1, 1)
//  Revision    : 1.0  initial release
// ============================================================================
module lstm_act
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DFLT,
    parameter int FRACT_WIDTH = FRACT_WIDTH_DFLT
) (
    input  act_mode_t                     mode_i,
    input  logic signed [DATA_WIDTH-1:0]  x_i,
    output logic signed [DATA_WIDTH-1:0]  y_o
);

    // Two guard bits keep 0.5 + x/4 and the clamp bounds free of overflow
    localparam int EW = DATA_WIDTH + 2;
    localparam logic signed [EW-1:0] ONE  = EW'(64'sd1 <<< FRACT_WIDTH);
    localparam logic signed [EW-1:0] HALF = EW'(64'sd1 <<< (FRACT_WIDTH - 1));

    logic signed [EW-1:0] x_ext;
    logic signed [EW-1:0] y_ext;
    logic signed [EW-1:0] lo;

    // Select the linear segment, then clamp to the mode's output range
    always_comb begin
        x_ext = EW'(x_i);
        if (mode_i == ACT_TANH) begin
            y_ext = x_ext;
            lo    = -ONE;
        end else begin
            y_ext = (x_ext >>> 2) + HALF;
            lo    = '0;
        end
        if (y_ext > ONE) begin
            y_ext = ONE;
        end else if (y_ext < lo) begin
            y_ext = lo;
        end
    end

    assign y_o = DATA_WIDTH'(y_ext);

endmodule
`default_nettype wire

// File: rtl/lstm_cell_seq.sv
`default_nettype none
// ============================================================================
//  Module      : lstm_cell_seq
//  Description : Single LSTM cell, one element per step, evaluated
//                sequentially on one multiplier. Gate pre-activations are
//                accumulated f, i, g, o, one product per cycle, each gate
//                activated on the cycle after it completes. The cell and
//                hidden state update happens in a single UPD cycle and the
//                result is held until the consumer takes it.
//  Revision    : 1.0  initial release
// ============================================================================
module lstm_cell_seq
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DFLT,
    parameter int FRACT_WIDTH = FRACT_WIDTH_DFLT,
    parameter int IN_DIM      = IN_DIM_DFLT
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic                                    seq_start,
    input  logic [IN_DIM*DATA_WIDTH-1:0]            x,
    input  logic [4*(IN_DIM+1)*DATA_WIDTH-1:0]      w,
    input  logic [4*DATA_WIDTH-1:0]                 b,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [DATA_WIDTH-1:0]                   c_out,
    output logic [DATA_WIDTH-1:0]                   h_out
);

    localparam int K      = IN_DIM + 1;
    localparam int TW     = (K > 1) ? $clog2(K) : 1;
    localparam int PROD_W = 2 * DATA_WIDTH;
    // K full products plus the aligned bias, with a sign guard bit
    localparam int ACC_W  = PROD_W + $clog2(K + 1) + 1;
    localparam int CELL_W = PROD_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                        state_q;
    gate_t                         gate_q;
    logic [TW-1:0]                 term_q;
    logic [IN_DIM*DATA_WIDTH-1:0]  x_q;
    logic                          seq_q;
    logic signed [ACC_W-1:0]       acc_q;
    logic signed [DATA_WIDTH-1:0]  pre_q;
    gate_t                         pre_gate_q;
    logic                          pre_vld_q;
    logic signed [DATA_WIDTH-1:0]  act_q [4];
    logic signed [DATA_WIDTH-1:0]  c_prev_q;
    logic signed [DATA_WIDTH-1:0]  h_prev_q;
    logic signed [DATA_WIDTH-1:0]  c_out_q;
    logic signed [DATA_WIDTH-1:0]  h_out_q;
    logic                          out_valid_q;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0]  w_c_prev;
    logic signed [DATA_WIDTH-1:0]  w_h_prev;
    int                            w_widx;
    logic signed [DATA_WIDTH-1:0]  w_wsel;
    logic signed [DATA_WIDTH-1:0]  w_bsel;
    logic signed [DATA_WIDTH-1:0]  w_opsel;
    logic signed [PROD_W-1:0]      w_prod;
    logic signed [ACC_W-1:0]       w_acc_base;
    logic signed [ACC_W-1:0]       acc_d;
    logic signed [DATA_WIDTH-1:0]  pre_d;

    logic signed [PROD_W-1:0]      w_fc;
    logic signed [PROD_W-1:0]      w_ig;
    logic signed [CELL_W-1:0]      w_cell_sum;
    logic signed [DATA_WIDTH-1:0]  c_new_d;
    logic signed [PROD_W-1:0]      w_oh;
    logic signed [DATA_WIDTH-1:0]  h_new_d;

    act_mode_t                     w_act_mode;
    logic signed [DATA_WIDTH-1:0]  w_act_x;
    logic signed [DATA_WIDTH-1:0]  w_act_y;

    // Single MAC: pick this cycle's weight/operand, fold the bias in on the
    // first term of each gate, and form the saturated pre-activation
    always_comb begin
        w_c_prev = seq_q ? '0 : c_prev_q;
        w_h_prev = seq_q ? '0 : h_prev_q;
        w_widx   = int'(gate_q) * K + int'(term_q);
        w_wsel   = $signed(w[w_widx*DATA_WIDTH +: DATA_WIDTH]);
        w_bsel   = $signed(b[int'(gate_q)*DATA_WIDTH +: DATA_WIDTH]);
        if (int'(term_q) < IN_DIM) begin
            w_opsel = $signed(x_q[int'(term_q)*DATA_WIDTH +: DATA_WIDTH]);
        end else begin
            w_opsel = w_h_prev;
        end
        w_prod     = PROD_W'(w_wsel) * PROD_W'(w_opsel);
        w_acc_base = (term_q == '0) ? (ACC_W'(w_bsel) <<< FRACT_WIDTH) : acc_q;
        acc_d      = w_acc_base + ACC_W'(w_prod);
        pre_d      = DATA_WIDTH'(saturate(SAT_W'(acc_d >>> FRACT_WIDTH), DATA_WIDTH));
    end

    // Cell update from the stored activations; also steers the shared
    // activation unit (gate activations during MAC/ACT, tanh(c) in UPD)
    always_comb begin
        w_fc       = PROD_W'(act_q[GATE_F]) * PROD_W'(w_c_prev);
        w_ig       = PROD_W'(act_q[GATE_I]) * PROD_W'(act_q[GATE_G]);
        w_cell_sum = CELL_W'(w_fc) + CELL_W'(w_ig);
        c_new_d    = DATA_WIDTH'(saturate(SAT_W'(w_cell_sum >>> FRACT_WIDTH), DATA_WIDTH));
        if (state_q == ST_UPD) begin
            w_act_mode = ACT_TANH;
            w_act_x    = c_new_d;
        end else begin
            w_act_mode = (pre_gate_q == GATE_G) ? ACT_TANH : ACT_SIGMOID;
            w_act_x    = pre_q;
        end
    end

    // Hidden state from the output gate and the squashed new cell state
    always_comb begin
        w_oh    = PROD_W'(act_q[GATE_O]) * PROD_W'(w_act_y);
        h_new_d = DATA_WIDTH'(saturate(SAT_W'(w_oh >>> FRACT_WIDTH), DATA_WIDTH));
    end

    lstm_act #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) u_act (
        .mode_i (w_act_mode),
        .x_i    (w_act_x),
        .y_o    (w_act_y)
    );

    // Step sequencer: IDLE -> MAC (4*K cycles) -> ACT -> UPD -> OUT -> IDLE.
    // out_valid is registered on the 4*K+2'th edge after accept, so the
    // consumer first samples it high on the 4*K+3'th edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gate_q      <= GATE_F;
            term_q      <= '0;
            x_q         <= '0;
            seq_q       <= 1'b0;
            acc_q       <= '0;
            pre_q       <= '0;
            pre_gate_q  <= GATE_F;
            pre_vld_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                act_q[i] <= '0;
            end
            c_prev_q    <= '0;
            h_prev_q    <= '0;
            c_out_q     <= '0;
            h_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pre_vld_q <= 1'b0;
            if (pre_vld_q) begin
                act_q[pre_gate_q] <= w_act_y;
            end
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q     <= x;
                        seq_q   <= seq_start;
                        gate_q  <= GATE_F;
                        term_q  <= '0;
                        state_q <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_q <= acc_d;
                    if (term_q == TW'(K - 1)) begin
                        term_q     <= '0;
                        pre_q      <= pre_d;
                        pre_gate_q <= gate_q;
                        pre_vld_q  <= 1'b1;
                        if (gate_q == GATE_O) begin
                            state_q <= ST_ACT;
                        end else begin
                            gate_q <= gate_t'(gate_q + 2'd1);
                        end
                    end else begin
                        term_q <= term_q + TW'(1);
                    end
                end
                ST_ACT: begin
                    state_q <= ST_UPD;
                end
                ST_UPD: begin
                    c_out_q     <= c_new_d;
                    h_out_q     <= h_new_d;
                    c_prev_q    <= c_new_d;
                    h_prev_q    <= h_new_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign c_out     = c_out_q;
    assign h_out     = h_out_q;

endmodule
`default_nettype wire

// File: tb/tb_lstm_cell_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lstm_cell_seq
//  Description : Directed self-checking bench for lstm_cell_seq (Q8.8,
//                IN_DIM = 2). Expected values are hand-computed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lstm_cell_seq;

    localparam int DW = 16;
    localparam int XW = 2 * DW;
    localparam int WW = 4 * 3 * DW;
    localparam int BW = 4 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          seq_start;
    logic [XW-1:0] x;
    logic [WW-1:0] w;
    logic [BW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] c_out;
    logic [DW-1:0] h_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lstm_cell_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .seq_start (seq_start),
        .x         (x),
        .w         (w),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out),
        .h_out     (h_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Present a step and hold in_valid for exactly the accept edge.
    // Entered and left #1 after a rising edge.
    task automatic launch(input logic seq, input logic [XW-1:0] xv,
                          input logic [WW-1:0] wv, input logic [BW-1:0] bv);
        int n;
        n = 0;
        x = xv; w = wv; b = bv; seq_start = seq;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        seq_start = 1'b0;
    endtask

    // Number of rising edges after the accept edge until the one that
    // samples out_valid high (value observed on the preceding falling edge)
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 60);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic step(input string tag, input logic seq, input logic [XW-1:0] xv,
                        input logic [WW-1:0] wv, input logic [BW-1:0] bv,
                        input logic [DW-1:0] c_exp, input logic [DW-1:0] h_exp);
        int lat;
        launch(seq, xv, wv, bv);
        wait_valid(lat);
        check({tag, "_lat"}, lat, 32'd15);
        check({tag, "_c"}, {16'd0, c_out}, {16'd0, c_exp});
        check({tag, "_h"}, {16'd0, h_out}, {16'd0, h_exp});
        release_out();
    endtask

    // Bias word {o, g, i, f}
    localparam logic [BW-1:0] B_018 = {16'h0400, 16'h0080, 16'h0400, 16'h0000};

    initial begin
        logic [XW-1:0] x3;
        logic [WW-1:0] w3;
        logic [BW-1:0] b3;
        logic [WW-1:0] wg;
        logic [BW-1:0] bg;
        logic [DW-1:0] c0;
        logic [DW-1:0] h0;
        logic          stable;
        int            lat;

        rst = 1'b1; in_valid = 1'b0; seq_start = 1'b0; out_ready = 1'b0;
        x = '0; w = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_c_out", {16'd0, c_out}, 32'd0);
        check("rst_h_out", {16'd0, h_out}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // All-zero parameters: f=i=o=0.5, g=0 -> c=h=0
        step("zero", 1'b1, '0, '0, '0, 16'h0000, 16'h0000);

        // Bias-only: f=0.5 i=1 g=0.5 o=1
        step("bias1", 1'b1, '0, '0, B_018, 16'h0080, 16'h0080);
        step("bias2", 1'b0, '0, '0, B_018, 16'h00C0, 16'h00C0);

        // Mixed signs, uses h_prev=0.75, c_prev=0.75:
        // f=0.5 i=0.4375 g=-1 o=0.9375 -> c=-16/256, h=-15/256
        x3 = {16'hFF00, 16'h0100};
        w3 = {16'h0100, 16'h0000, 16'h0100,    // o: h, x1, x0
              16'h0000, 16'h0200, 16'hFF00,    // g
              16'h0100, 16'h0000, 16'h0000,    // i
              16'h0000, 16'h0080, 16'h0100};   // f
        b3 = {16'h0000, 16'h0000, 16'hFF00, 16'hFF80};
        step("mixed", 1'b0, x3, w3, b3, 16'hFFF0, 16'hFFF1);

        // Saturating g gate with seq_start clearing the negative c_prev
        wg = {16'h0000, 16'h0000, 16'h0000,
              16'h7FFF, 16'h7FFF, 16'h7FFF,
              16'h0000, 16'h0000, 16'h0000,
              16'h0000, 16'h0000, 16'h0000};
        bg = {16'h0400, 16'h7FFF, 16'h0400, 16'h0000};
        step("gsat", 1'b1, {16'h7FFF, 16'h7FFF}, wg, bg, 16'h0100, 16'h0100);

        // Back-pressure: hold the result 10 cycles, poke in_valid meanwhile
        launch(1'b1, '0, '0, B_018);
        wait_valid(lat);
        check("bp_lat", lat, 32'd15);
        c0 = c_out; h0 = h_out;
        check("bp_c", {16'd0, c0}, 32'h0080);
        check("bp_h", {16'd0, h0}, 32'h0080);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin
                in_valid = 1'b1; x = 32'h1234_5678; seq_start = 1'b1;
            end
            if (i == 5) begin
                in_valid = 1'b0; seq_start = 1'b0;
            end
            stable = stable & (c_out == c0) & (h_out == h0) & out_valid & ~in_ready;
        end
        check("bp_hold_stable", {31'd0, stable}, 32'd1);
        release_out();
        check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        check("bp_idle_valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-MAC discards the step and clears c_prev/h_prev
        launch(1'b0, '0, '0, B_018);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        step("after_abort", 1'b0, '0, '0, '0, 16'h0000, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
